// File: rtl/ps2_command.sv
// Host-to-keyboard command sequencer for the shared PS/2 clock/data pair.
// Runs the reset/BAT and LED-update sequences, with retries and per-wait timeouts.
module ps2_command #(
  parameter int INHIBIT = 128,
  parameter int TIMEOUT = 16383,
  parameter int RETRIES = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ce,
  input  logic [1:0] ps2,
  output logic [1:0] ps2_oe,
  input  logic       init,
  input  logic [2:0] leds,
  input  logic [7:0] rx_code,
  input  logic       rx_strobe,
  output logic       busy,
  output logic       error,
  output logic [2:0] dbg_state
);

  localparam int CW = $clog2(TIMEOUT * 64 + 1);
  localparam int TW = $clog2(RETRIES + 1);
  localparam logic [CW-1:0] INHIBIT_LOAD = CW'(INHIBIT - 1);
  localparam logic [CW-1:0] TIMEOUT_LOAD = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] BAT_LOAD     = CW'(TIMEOUT * 64 - 1);
  localparam logic [TW-1:0] LAST_TRY     = TW'(RETRIES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INHIBIT = 3'd1,
    S_REQ     = 3'd2,
    S_SHIFT   = 3'd3,
    S_ACKBIT  = 3'd4,
    S_RESP    = 3'd5
  } state_t;

  typedef enum logic {
    SEQ_RESET = 1'b0,
    SEQ_LEDS  = 1'b1
  } seq_t;

  state_t         state, state_n;
  seq_t           seq, seq_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [3:0]     k, k_n;
  logic           tx_bit, tx_bit_n;
  logic [TW-1:0]  tries, tries_n;
  logic           step, step_n;
  logic           bat, bat_n;
  logic           init_pend, init_pend_n;
  logic           led_pend, led_pend_n;
  logic [2:0]     leds_sent, leds_sent_n;
  logic           error_q, error_n;
  logic           init_d;
  logic [1:0]     sync1, sync2;
  logic           clk_prev;
  logic           fall;
  logic           fail;
  logic [7:0]     tx_byte;

  assign fall = clk_prev & ~sync2[0];

  always_comb begin
    tx_byte = 8'hFF;
    if (seq == SEQ_LEDS) tx_byte = step ? {5'b0, leds_sent} : 8'hED;
  end

  // rx_code/rx_strobe is a one-tick valid with no ready: a byte is consumed
  // only while in RESP, and is never held back from the scancode decoder.
  always_comb begin
    state_n     = state;
    seq_n       = seq;
    cnt_n       = cnt;
    k_n         = k;
    tx_bit_n    = tx_bit;
    tries_n     = tries;
    step_n      = step;
    bat_n       = bat;
    init_pend_n = init_pend;
    led_pend_n  = led_pend;
    leds_sent_n = leds_sent;
    error_n     = error_q;
    fail        = 1'b0;

    if (init && !init_d) init_pend_n = 1'b1;
    if ((leds != leds_sent) && !(seq == SEQ_LEDS && state != S_IDLE)) led_pend_n = 1'b1;

    case (state)
      S_IDLE: begin
        if (init_pend || led_pend) begin
          state_n = S_INHIBIT;
          cnt_n   = INHIBIT_LOAD;
          step_n  = 1'b0;
          bat_n   = 1'b0;
          tries_n = '0;
          error_n = 1'b0;
          if (init_pend) begin
            seq_n       = SEQ_RESET;
            init_pend_n = 1'b0;
          end else begin
            seq_n       = SEQ_LEDS;
            led_pend_n  = 1'b0;
            leds_sent_n = leds;
          end
        end
      end

      S_INHIBIT: begin
        if (cnt == '0) state_n = S_REQ;
        else           cnt_n   = cnt - 1'b1;
      end

      S_REQ: begin
        state_n  = S_SHIFT;
        k_n      = 4'd0;
        tx_bit_n = 1'b0;
        cnt_n    = TIMEOUT_LOAD;
      end

      S_SHIFT: begin
        if (fall) begin
          cnt_n = TIMEOUT_LOAD;
          k_n   = k + 4'd1;
          // k holds edges already seen, so this edge is number k+1
          if (k == 4'd9) begin
            tx_bit_n = 1'b1;
            state_n  = S_ACKBIT;
          end else if (k == 4'd8) begin
            tx_bit_n = ~^tx_byte;
          end else begin
            tx_bit_n = tx_byte[k[2:0]];
          end
        end else if (cnt == '0) begin
          fail = 1'b1;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end

      S_ACKBIT: begin
        if (fall) begin
          if (!sync2[1]) begin
            state_n = S_RESP;
            cnt_n   = TIMEOUT_LOAD;
          end else begin
            fail = 1'b1;
          end
        end else if (cnt == '0) begin
          fail = 1'b1;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end

      S_RESP: begin
        if (rx_strobe) begin
          if (bat) begin
            if (rx_code == 8'hAA) begin
              // the keyboard blanks its LEDs after BAT, so always resend them
              state_n    = S_IDLE;
              led_pend_n = 1'b1;
            end else if (rx_code == 8'hFE) begin
              fail = 1'b1;
            end
          end else if (rx_code == 8'hFA) begin
            tries_n = '0;
            if (seq == SEQ_RESET) begin
              bat_n = 1'b1;
              cnt_n = BAT_LOAD;
            end else if (!step) begin
              step_n  = 1'b1;
              state_n = S_INHIBIT;
              cnt_n   = INHIBIT_LOAD;
            end else begin
              state_n = S_IDLE;
            end
          end else if (rx_code == 8'hFE) begin
            fail = 1'b1;
          end
        end else if (cnt == '0) begin
          fail = 1'b1;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end

      default: state_n = S_IDLE;
    endcase

    if (fail) begin
      if (tries == LAST_TRY) begin
        state_n = S_IDLE;
        error_n = 1'b1;
        if (seq == SEQ_RESET) init_pend_n = 1'b0;
        else                  led_pend_n  = 1'b0;
      end else begin
        tries_n = tries + 1'b1;
        state_n = S_INHIBIT;
        cnt_n   = INHIBIT_LOAD;
        bat_n   = 1'b0;
        // a failed BAT wait restarts from the 0xFF byte itself
        if (seq == SEQ_RESET) step_n = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      seq       <= SEQ_RESET;
      cnt       <= '0;
      k         <= 4'd0;
      tx_bit    <= 1'b1;
      tries     <= '0;
      step      <= 1'b0;
      bat       <= 1'b0;
      init_pend <= 1'b0;
      led_pend  <= 1'b0;
      leds_sent <= 3'b000;
      error_q   <= 1'b0;
      init_d    <= 1'b0;
      sync1     <= 2'b11;
      sync2     <= 2'b11;
      clk_prev  <= 1'b1;
    end else if (ce) begin
      state     <= state_n;
      seq       <= seq_n;
      cnt       <= cnt_n;
      k         <= k_n;
      tx_bit    <= tx_bit_n;
      tries     <= tries_n;
      step      <= step_n;
      bat       <= bat_n;
      init_pend <= init_pend_n;
      led_pend  <= led_pend_n;
      leds_sent <= leds_sent_n;
      error_q   <= error_n;
      init_d    <= init;
      sync1     <= ps2;
      sync2     <= sync1;
      clk_prev  <= sync2[0];
    end
  end

  always_comb begin
    ps2_oe = 2'b00;
    case (state)
      S_INHIBIT:        ps2_oe = 2'b01;
      S_REQ:            ps2_oe = 2'b10;
      S_SHIFT, S_ACKBIT: ps2_oe = {~tx_bit, 1'b0};
      default:          ps2_oe = 2'b00;
    endcase
  end

  assign busy      = (state != S_IDLE);
  assign error     = error_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_ps2_command.sv
// Bench for ps2_command: a PS/2 keyboard model clocks bytes out of the host
// and answers them, while a byte-level model predicts what reaches the wire.
module tb_ps2_command;

  localparam int INHIBIT = 20;
  localparam int TIMEOUT = 600;
  localparam int RETRIES = 3;

  logic       clock = 1'b0;
  logic       reset;
  logic       ce = 1'b0;
  logic [1:0] ps2;
  logic [1:0] ps2_oe;
  logic       init;
  logic [2:0] leds;
  logic [7:0] rx_code;
  logic       rx_strobe;
  logic       busy;
  logic       error;
  logic [2:0] dbg_state;

  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];
  logic [2:0] cur_leds;

  // open-drain bus: either side may pull a line low
  assign ps2 = {dev_data & ~ps2_oe[1], dev_clk & ~ps2_oe[0]};

  ps2_command #(.INHIBIT(INHIBIT), .TIMEOUT(TIMEOUT), .RETRIES(RETRIES)) dut (
    .clock     (clock),
    .reset     (reset),
    .ce        (ce),
    .ps2       (ps2),
    .ps2_oe    (ps2_oe),
    .init      (init),
    .leds      (leds),
    .rx_code   (rx_code),
    .rx_strobe (rx_strobe),
    .busy      (busy),
    .error     (error),
    .dbg_state (dbg_state)
  );

  // clock / reset block
  always #5 clock = ~clock;
  always @(negedge clock) ce = ($urandom_range(0, 2) != 0);

  task automatic wait_tick();
    @(posedge clock);
    while (!ce) @(posedge clock);
    #1;
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) wait_tick();
  endtask

  // reference model: odd parity bit and the byte stream of one LED update
  function automatic logic odd_parity(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) if (b[i]) ones++;
    return (ones % 2 == 0);
  endfunction

  task automatic push_leds_seq(input logic [2:0] v);
    exp_q.push_back(8'hED);
    exp_q.push_back({5'b00000, v});
  endtask

  function automatic logic [2:0] pick_new(input logic [2:0] old);
    logic [2:0] v;
    v = 3'($urandom_range(0, 7));
    while (v == old) v = 3'($urandom_range(0, 7));
    return v;
  endfunction

  task automatic send_rx(input logic [7:0] code);
    rx_code = code;
    rx_strobe = 1'b1;
    wait_tick();
    rx_strobe = 1'b0;
  endtask

  // keyboard model: receives one host byte, scoreboards it, then answers
  task automatic dev_byte(input logic [7:0] resp);
    int hp;
    int n;
    logic [7:0] b;
    logic [7:0] e;
    logic par, st, sp;
    hp = $urandom_range(4, 8);
    b = 8'h00; par = 1'b0; sp = 1'b0;
    n = 0;
    while (ps2_oe !== 2'b10 && n < 3000) begin wait_tick(); n++; end
    total++;
    if (ps2_oe !== 2'b10) begin
      bad++;
      $display("FAIL dev_request: ps2_oe=%b required 10 within 3000 ticks", ps2_oe);
      return;
    end
    wait_ticks(hp);
    st = ps2[1];
    for (int i = 1; i <= 10; i++) begin
      dev_clk = 1'b0;
      wait_ticks(hp);
      if (i <= 8) b[i-1] = ps2[1];
      else if (i == 9) par = ps2[1];
      else sp = ps2[1];
      dev_clk = 1'b1;
      wait_ticks(hp);
    end
    dev_data = 1'b0;
    wait_ticks(hp);
    dev_clk = 1'b0;
    wait_ticks(hp);
    dev_clk = 1'b1;
    wait_ticks(2);
    dev_data = 1'b1;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL wire_unexpected: byte %h seen, none expected", b);
      e = 8'h00;
    end else begin
      e = exp_q.pop_front();
    end
    total++;
    if (b !== e) begin bad++; $display("FAIL wire_byte: got %h required %h", b, e); end
    total++;
    if (par !== odd_parity(e)) begin bad++; $display("FAIL wire_parity: byte %h got %b required %b", e, par, odd_parity(e)); end
    total++;
    if (st !== 1'b0 || sp !== 1'b1) begin bad++; $display("FAIL wire_framing: start=%b stop=%b required 0/1", st, sp); end
    wait_ticks(3);
    send_rx(resp);
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b0; init = 1'b0; leds = 3'b000; cur_leds = 3'b000;
    rx_code = 8'h00; rx_strobe = 1'b0;
    repeat (5) @(posedge clock);
    #2;
    total++;
    if (ps2_oe !== 2'b00 || busy !== 1'b0 || error !== 1'b0) begin
      bad++; $display("FAIL reset_outputs: oe=%b busy=%b error=%b required 00/0/0", ps2_oe, busy, error);
    end
    total++;
    if (dbg_state !== 3'd0) begin bad++; $display("FAIL reset_state: got %0d required 0", dbg_state); end
    reset = 1'b1;
    n = 0;
    for (int i = 0; i < 10000; i++) begin
      wait_tick();
      if (ps2_oe !== 2'b00 || busy !== 1'b0) n++;
    end
    total++;
    if (n != 0) begin bad++; $display("FAIL reset_idle: %0d active ticks required 0", n); end
  endtask

  task automatic test_led_update();
    int n;
    leds = 3'b100; cur_leds = 3'b100;
    push_leds_seq(cur_leds);
    wait_tick();
    total++;
    if (ps2_oe !== 2'b00 || busy !== 1'b0) begin bad++; $display("FAIL led_start_early: oe=%b busy=%b required 00/0", ps2_oe, busy); end
    wait_tick();
    total++;
    if (ps2_oe !== 2'b01 || busy !== 1'b1) begin bad++; $display("FAIL led_start: oe=%b busy=%b required 01/1", ps2_oe, busy); end
    n = 0;
    while (ps2_oe === 2'b01 && n < 4 * INHIBIT) begin n++; wait_tick(); end
    total++;
    if (n != INHIBIT) begin bad++; $display("FAIL inhibit_len: got %0d ticks required %0d", n, INHIBIT); end
    dev_byte(8'hFA);
    dev_byte(8'hFA);
    total++;
    if (busy !== 1'b0 || error !== 1'b0) begin bad++; $display("FAIL led_done: busy=%b error=%b required 0/0", busy, error); end
  endtask

  task automatic test_reset_seq();
    int n;
    logic [2:0] nv;
    nv = pick_new(cur_leds);
    init = 1'b1; leds = nv; cur_leds = nv;
    exp_q.push_back(8'hFF);
    push_leds_seq(nv);
    wait_tick();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL init_start_early: busy=%b required 0", busy); end
    wait_tick();
    total++;
    if (ps2_oe !== 2'b01 || busy !== 1'b1) begin bad++; $display("FAIL init_start: oe=%b busy=%b required 01/1", ps2_oe, busy); end
    init = 1'b0;
    dev_byte(8'hFA);
    wait_ticks(5);
    send_rx(8'hAA);
    dev_byte(8'hFA);
    dev_byte(8'hFA);
    total++;
    if (busy !== 1'b0 || error !== 1'b0) begin bad++; $display("FAIL init_done: busy=%b error=%b required 0/0", busy, error); end
    n = 0;
    for (int i = 0; i < 300; i++) begin wait_tick(); if (busy !== 1'b0) n++; end
    total++;
    if (n != 0 || exp_q.size() != 0) begin bad++; $display("FAIL init_single_leds: busy_ticks=%0d left=%0d required 0/0", n, exp_q.size()); end
  endtask

  task automatic test_resend();
    logic [2:0] nv;
    nv = pick_new(cur_leds);
    leds = nv; cur_leds = nv;
    exp_q.push_back(8'hED);
    push_leds_seq(nv);
    dev_byte(8'hFE);
    dev_byte(8'hFA);
    dev_byte(8'hFA);
    total++;
    if (busy !== 1'b0 || error !== 1'b0 || exp_q.size() != 0) begin
      bad++; $display("FAIL resend_done: busy=%b error=%b left=%0d required 0/0/0", busy, error, exp_q.size());
    end
  endtask

  task automatic test_timeout();
    int n;
    logic [2:0] nv;
    nv = pick_new(cur_leds);
    leds = nv; cur_leds = nv;
    n = 0;
    while (ps2_oe !== 2'b01 && n < 50) begin wait_tick(); n++; end
    total++;
    if (ps2_oe !== 2'b01) begin bad++; $display("FAIL timeout_start: oe=%b required 01", ps2_oe); end
    for (int a = 0; a < RETRIES; a++) begin
      n = 0;
      while (ps2_oe === 2'b01 && n < 4 * INHIBIT) begin n++; wait_tick(); end
      total++;
      if (n != INHIBIT) begin bad++; $display("FAIL timeout_inhibit%0d: got %0d required %0d", a, n, INHIBIT); end
      n = 0;
      while (ps2_oe === 2'b10 && n < 2 * TIMEOUT) begin n++; wait_tick(); end
      total++;
      if (n != TIMEOUT + 1) begin bad++; $display("FAIL timeout_wait%0d: got %0d required %0d", a, n, TIMEOUT + 1); end
      if (a < RETRIES - 1) begin
        total++;
        if (ps2_oe !== 2'b01 || error !== 1'b0) begin bad++; $display("FAIL timeout_retry%0d: oe=%b error=%b required 01/0", a, ps2_oe, error); end
      end else begin
        total++;
        if (ps2_oe !== 2'b00 || busy !== 1'b0 || error !== 1'b1) begin
          bad++; $display("FAIL timeout_abandon: oe=%b busy=%b error=%b required 00/0/1", ps2_oe, busy, error);
        end
      end
    end
    n = 0;
    for (int i = 0; i < 100; i++) begin wait_tick(); if (busy !== 1'b0) n++; end
    total++;
    if (n != 0) begin bad++; $display("FAIL timeout_no_loop: %0d busy ticks required 0", n); end
    nv = pick_new(cur_leds);
    leds = nv; cur_leds = nv;
    wait_tick();
    total++;
    if (error !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL error_hold: error=%b busy=%b required 1/0", error, busy); end
    wait_tick();
    total++;
    if (error !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL error_clear: error=%b busy=%b required 0/1", error, busy); end
  endtask

  task automatic test_reset_midbyte();
    int n;
    int hp;
    logic [7:0] e;
    e = 8'hED;
    hp = $urandom_range(4, 8);
    n = 0;
    while (ps2_oe !== 2'b10 && n < 4 * INHIBIT) begin wait_tick(); n++; end
    total++;
    if (ps2_oe !== 2'b10) begin bad++; $display("FAIL midbyte_req: oe=%b required 10", ps2_oe); end
    wait_ticks(hp);
    for (int i = 1; i <= 5; i++) begin
      dev_clk = 1'b0;
      wait_ticks(hp);
      if (i < 5) begin dev_clk = 1'b1; wait_ticks(hp); end
    end
    total++;
    if (ps2_oe !== {~e[4], 1'b0}) begin bad++; $display("FAIL midbyte_bit4: oe=%b required %b", ps2_oe, {~e[4], 1'b0}); end
    #2 reset = 1'b0;
    #1;
    total++;
    if (ps2_oe !== 2'b00 || busy !== 1'b0 || error !== 1'b0) begin
      bad++; $display("FAIL midbyte_async: oe=%b busy=%b error=%b required 00/0/0", ps2_oe, busy, error);
    end
    dev_clk = 1'b1;
    repeat (3) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    total++;
    if (dbg_state !== 3'd0 || ps2_oe !== 2'b00) begin bad++; $display("FAIL midbyte_release: state=%0d oe=%b required 0/00", dbg_state, ps2_oe); end
  endtask

  initial begin
    test_reset();
    test_led_update();
    test_reset_seq();
    test_resend();
    test_timeout();
    test_reset_midbyte();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
